// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec
// Brief    : Single-cycle MIPS-style execute stage. Decode and compute are
//            combinational; every output is registered (1 clk latency).
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  pc,
  input  logic [31:0] readRs,
  input  logic [31:0] readRt,
  input  logic [31:0] readRd,
  input  logic [4:0]  readRdAddress,
  input  logic [4:0]  readRtAddress,
  input  logic [4:0]  shiftNumber,
  input  logic [15:0] I_immediate,
  input  logic [25:0] J_immediate,
  input  logic [5:0]  operand,
  input  logic [5:0]  funct,
  output logic [4:0]  writeBackAddress,
  output logic [31:0] result,
  output logic        isZero,
  output logic        isBranch,
  output logic        isJAL,
  output logic [1:0]  loadWrite,
  output logic [4:0]  loadWriteAddress,
  output logic [1:0]  inOut,
  output logic [4:0]  inOutAddress
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_IN    = 6'h20;
  localparam logic [5:0] OP_OUT   = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] rs_plus_imm;
  logic [4:0]  pc_next;
  logic        rs_eq_rt;

  // The rd register value is not needed by any supported instruction.
  logic unused_inputs;
  assign unused_inputs = ^readRd;

  assign imm_sext    = {{16{I_immediate[15]}}, I_immediate};
  assign imm_zext    = {16'h0000, I_immediate};
  assign rs_plus_imm = readRs + imm_sext;
  assign pc_next     = pc + 5'd1;
  assign rs_eq_rt    = (readRs == readRt);

  logic [4:0]  n_wba;
  logic [31:0] n_result;
  logic        n_branch;
  logic        n_jal;
  logic [1:0]  n_lw;
  logic [4:0]  n_lw_addr;
  logic [1:0]  n_io;
  logic [4:0]  n_io_addr;
  logic        n_valid;    // decoded a supported instruction
  logic        n_cmp_br;   // beq/bne: isZero reports Rs==Rt instead of result==0
  logic        n_zero;

  // Combinational decode and compute; defaults describe a nop.
  always_comb begin
    n_wba     = 5'd0;
    n_result  = 32'd0;
    n_branch  = 1'b0;
    n_jal     = 1'b0;
    n_lw      = 2'b00;
    n_lw_addr = 5'd0;
    n_io      = 2'b00;
    n_io_addr = 5'd0;
    n_valid   = 1'b1;
    n_cmp_br  = 1'b0;
    case (operand)
      OP_RTYPE: begin
        n_wba = readRdAddress;
        case (funct)
          FN_ADD: n_result = readRs + readRt;
          FN_SUB: n_result = readRs - readRt;
          FN_AND: n_result = readRs & readRt;
          FN_OR:  n_result = readRs | readRt;
          FN_SLT: n_result = {31'd0, ($signed(readRs) < $signed(readRt))};
          FN_SLL: n_result = readRt << shiftNumber;
          FN_SRL: n_result = readRt >> shiftNumber;
          FN_SRA: n_result = $unsigned($signed(readRt) >>> shiftNumber);
          FN_JR: begin
            n_branch = 1'b1;
            n_wba    = readRs[4:0];
          end
          default: begin
            n_valid = 1'b0;
            n_wba   = 5'd0;
          end
        endcase
      end
      OP_ADDI: begin n_wba = readRtAddress; n_result = rs_plus_imm; end
      OP_ANDI: begin n_wba = readRtAddress; n_result = readRs & imm_zext; end
      OP_ORI:  begin n_wba = readRtAddress; n_result = readRs | imm_zext; end
      OP_XORI: begin n_wba = readRtAddress; n_result = readRs ^ imm_zext; end
      OP_LUI:  begin n_wba = readRtAddress; n_result = {I_immediate, 16'h0000}; end
      OP_BEQ, OP_BNE: begin
        n_cmp_br = 1'b1;
        if ((operand == OP_BEQ) == rs_eq_rt) begin
          n_branch = 1'b1;
          n_wba    = pc_next + I_immediate[4:0];
        end
      end
      OP_J: begin
        n_branch = 1'b1;
        n_wba    = J_immediate[4:0];
      end
      OP_JAL: begin
        n_branch = 1'b1;
        n_jal    = 1'b1;
        n_wba    = J_immediate[4:0];
        n_result = {27'd0, pc_next};
      end
      OP_LW, OP_SW: begin
        n_lw      = (operand == OP_LW) ? 2'b10 : 2'b01;
        n_wba     = readRtAddress;
        n_lw_addr = rs_plus_imm[4:0];
      end
      OP_IN, OP_OUT: begin
        n_io      = (operand == OP_IN) ? 2'b10 : 2'b01;
        n_io_addr = I_immediate[4:0];
      end
      default: n_valid = 1'b0;
    endcase
    if (n_cmp_br) n_zero = rs_eq_rt;
    else          n_zero = n_valid && (n_result == 32'd0);
  end

  // Output register; reset overrides and discards the decoded instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      writeBackAddress <= 5'd0;
      result           <= 32'd0;
      isZero           <= 1'b0;
      isBranch         <= 1'b0;
      isJAL            <= 1'b0;
      loadWrite        <= 2'b00;
      loadWriteAddress <= 5'd0;
      inOut            <= 2'b00;
      inOutAddress     <= 5'd0;
    end else begin
      writeBackAddress <= n_wba;
      result           <= n_result;
      isZero           <= n_zero;
      isBranch         <= n_branch;
      isJAL            <= n_jal;
      loadWrite        <= n_lw;
      loadWriteAddress <= n_lw_addr;
      inOut            <= n_io;
      inOutAddress     <= n_io_addr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec
// Brief    : Directed self-checking bench for alu_exec.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  pc;
  logic [31:0] readRs, readRt, readRd;
  logic [4:0]  readRdAddress, readRtAddress, shiftNumber;
  logic [15:0] I_immediate;
  logic [25:0] J_immediate;
  logic [5:0]  operand, funct;
  logic [4:0]  writeBackAddress;
  logic [31:0] result;
  logic        isZero, isBranch, isJAL;
  logic [1:0]  loadWrite;
  logic [4:0]  loadWriteAddress;
  logic [1:0]  inOut;
  logic [4:0]  inOutAddress;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec dut (
    .clk(clk), .reset(reset), .pc(pc),
    .readRs(readRs), .readRt(readRt), .readRd(readRd),
    .readRdAddress(readRdAddress), .readRtAddress(readRtAddress),
    .shiftNumber(shiftNumber), .I_immediate(I_immediate),
    .J_immediate(J_immediate), .operand(operand), .funct(funct),
    .writeBackAddress(writeBackAddress), .result(result),
    .isZero(isZero), .isBranch(isBranch), .isJAL(isJAL),
    .loadWrite(loadWrite), .loadWriteAddress(loadWriteAddress),
    .inOut(inOut), .inOutAddress(inOutAddress)
  );

  always #5 clk = ~clk;

  // Single comparison point.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against expected values.
  task automatic expect_all(input string tag, input logic [31:0] e_res, input logic [4:0] e_wba,
                            input logic e_zero, input logic e_br, input logic e_jal,
                            input logic [1:0] e_lw, input logic [4:0] e_lwa,
                            input logic [1:0] e_io, input logic [4:0] e_ioa);
    chk({tag, ".result"},           result,                  e_res);
    chk({tag, ".writeBackAddress"}, {27'd0, writeBackAddress}, {27'd0, e_wba});
    chk({tag, ".isZero"},           {31'd0, isZero},         {31'd0, e_zero});
    chk({tag, ".isBranch"},         {31'd0, isBranch},       {31'd0, e_br});
    chk({tag, ".isJAL"},            {31'd0, isJAL},          {31'd0, e_jal});
    chk({tag, ".loadWrite"},        {30'd0, loadWrite},      {30'd0, e_lw});
    chk({tag, ".loadWriteAddress"}, {27'd0, loadWriteAddress}, {27'd0, e_lwa});
    chk({tag, ".inOut"},            {30'd0, inOut},          {30'd0, e_io});
    chk({tag, ".inOutAddress"},     {27'd0, inOutAddress},   {27'd0, e_ioa});
  endtask

  // Present one instruction; other fields keep benign values.
  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [4:0] rta, input logic [4:0] rda,
                       input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] jimm,
                       input logic [4:0] pcv);
    operand = op; funct = fn; readRs = rs; readRt = rt;
    readRtAddress = rta; readRdAddress = rda; shiftNumber = sh;
    I_immediate = imm; J_immediate = jimm; pc = pcv;
    readRd = 32'hDEADBEEF;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    // Instruction present during reset must be discarded.
    drive(6'h08, 6'h00, 32'd7, 32'd0, 5'd16, 5'd0, 5'd0, 16'h0003, 26'd0, 5'd0);
    step();
    expect_all("reset", 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    step();
    expect_all("reset2", 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    #2 reset = 1'b0;

    // addi Rs=0 imm=3 rt=16
    drive(6'h08, 6'h00, 32'd0, 32'd0, 5'd16, 5'd0, 5'd0, 16'h0003, 26'd0, 5'd0);
    step(); expect_all("addi", 32'd3, 5'd16, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    // addi with negative immediate: 5 + (-1)
    drive(6'h08, 6'h00, 32'd5, 32'd0, 5'd1, 5'd0, 5'd0, 16'hFFFF, 26'd0, 5'd0);
    step(); expect_all("addi_neg", 32'd4, 5'd1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    // sra
    drive(6'h00, 6'h03, 32'd0, 32'h80000000, 5'd0, 5'd18, 5'd1, 16'h0, 26'd0, 5'd0);
    step(); expect_all("sra", 32'hC0000000, 5'd18, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    // srl
    drive(6'h00, 6'h02, 32'd0, 32'h80000000, 5'd0, 5'd3, 5'd4, 16'h0, 26'd0, 5'd0);
    step(); expect_all("srl", 32'h08000000, 5'd3, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    // sll
    drive(6'h00, 6'h00, 32'd0, 32'd1, 5'd0, 5'd2, 5'd31, 16'h0, 26'd0, 5'd0);
    step(); expect_all("sll", 32'h80000000, 5'd2, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    // slt signed: -1 < 1
    drive(6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1, 5'd0, 5'd5, 5'd0, 16'h0, 26'd0, 5'd0);
    step(); expect_all("slt", 32'd1, 5'd5, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    // sub 3-5 wraps
    drive(6'h00, 6'h22, 32'd3, 32'd5, 5'd0, 5'd7, 5'd0, 16'h0, 26'd0, 5'd0);
    step(); expect_all("sub", 32'hFFFFFFFE, 5'd7, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    // add wraps to zero
    drive(6'h00, 6'h20, 32'hFFFFFFFF, 32'd1, 5'd0, 5'd9, 5'd0, 16'h0, 26'd0, 5'd0);
    step(); expect_all("add_wrap", 32'd0, 5'd9, 1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    // and / or
    drive(6'h00, 6'h24, 32'h0000F0F0, 32'h0000FF00, 5'd0, 5'd10, 5'd0, 16'h0, 26'd0, 5'd0);
    step(); expect_all("and", 32'h0000F000, 5'd10, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    drive(6'h00, 6'h25, 32'h0000F0F0, 32'h0000FF00, 5'd0, 5'd11, 5'd0, 16'h0, 26'd0, 5'd0);
    step(); expect_all("or", 32'h0000FFF0, 5'd11, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    // lui / ori / andi / xori (zero-extended immediates)
    drive(6'h0F, 6'h00, 32'd0, 32'd0, 5'd4, 5'd0, 5'd0, 16'hABCD, 26'd0, 5'd0);
    step(); expect_all("lui", 32'hABCD0000, 5'd4, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    drive(6'h0D, 6'h00, 32'h12340000, 32'd0, 5'd6, 5'd0, 5'd0, 16'h8001, 26'd0, 5'd0);
    step(); expect_all("ori", 32'h12348001, 5'd6, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    drive(6'h0C, 6'h00, 32'hFFFFFFFF, 32'd0, 5'd8, 5'd0, 5'd0, 16'h8000, 26'd0, 5'd0);
    step(); expect_all("andi", 32'h00008000, 5'd8, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    drive(6'h0E, 6'h00, 32'd0, 32'd0, 5'd12, 5'd0, 5'd0, 16'hFFFF, 26'd0, 5'd0);
    step(); expect_all("xori", 32'h0000FFFF, 5'd12, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    // bne taken: 14+1+1 = 16
    drive(6'h05, 6'h00, 32'd5, 32'd0, 5'd0, 5'd0, 5'd0, 16'h0001, 26'd0, 5'd14);
    step(); expect_all("bne_taken", 32'd0, 5'd16, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    // bne not taken, Rs==Rt
    drive(6'h05, 6'h00, 32'd7, 32'd7, 5'd3, 5'd0, 5'd0, 16'h0001, 26'd0, 5'd14);
    step(); expect_all("bne_not", 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    // beq taken with negative offset: 31+1-2 = 30
    drive(6'h04, 6'h00, 32'd9, 32'd9, 5'd0, 5'd0, 5'd0, 16'hFFFE, 26'd0, 5'd31);
    step(); expect_all("beq_neg", 32'd0, 5'd30, 1'b1, 1'b1, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    // beq target wraps: 31+1+0 = 32 -> 0
    drive(6'h04, 6'h00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'd0, 5'd31);
    step(); expect_all("beq_wrap", 32'd0, 5'd0, 1'b1, 1'b1, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    // beq not taken
    drive(6'h04, 6'h00, 32'd1, 32'd2, 5'd0, 5'd0, 5'd0, 16'h0003, 26'd0, 5'd4);
    step(); expect_all("beq_not", 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    // jal
    drive(6'h03, 6'h00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100018, 5'd23);
    step(); expect_all("jal", 32'd24, 5'd24, 1'b0, 1'b1, 1'b1, 2'b00, 5'd0, 2'b00, 5'd0);
    // jal return address wraps: pc=31 -> 0
    drive(6'h03, 6'h00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000005, 5'd31);
    step(); expect_all("jal_wrap", 32'd0, 5'd5, 1'b1, 1'b1, 1'b1, 2'b00, 5'd0, 2'b00, 5'd0);
    // j
    drive(6'h02, 6'h00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF, 5'd3);
    step(); expect_all("j", 32'd0, 5'd31, 1'b1, 1'b1, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    // jr
    drive(6'h00, 6'h08, 32'h12345673, 32'd0, 5'd0, 5'd9, 5'd0, 16'h0, 26'd0, 5'd0);
    step(); expect_all("jr", 32'd0, 5'd19, 1'b1, 1'b1, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    // lw
    drive(6'h23, 6'h00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 16'd16, 26'd0, 5'd0);
    step(); expect_all("lw", 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b10, 5'd16, 2'b00, 5'd0);
    // sw: 20 + (-4) = 16
    drive(6'h2B, 6'h00, 32'd20, 32'd0, 5'd13, 5'd0, 5'd0, 16'hFFFC, 26'd0, 5'd0);
    step(); expect_all("sw", 32'd0, 5'd13, 1'b1, 1'b0, 1'b0, 2'b01, 5'd16, 2'b00, 5'd0);
    // in / out
    drive(6'h20, 6'h00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 16'h001F, 26'd0, 5'd0);
    step(); expect_all("in", 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 2'b10, 5'd31);
    drive(6'h21, 6'h00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 16'h0005, 26'd0, 5'd0);
    step(); expect_all("out", 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 2'b01, 5'd5);

    // Reset mid-stream after a nonzero result
    drive(6'h08, 6'h00, 32'd40, 32'd0, 5'd21, 5'd0, 5'd0, 16'h0002, 26'd0, 5'd0);
    step(); expect_all("pre_rst", 32'd42, 5'd21, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    reset = 1'b1;
    step(); expect_all("mid_rst", 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    reset = 1'b0;
    step(); expect_all("post_rst", 32'd42, 5'd21, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);

    // Undefined opcode with busy fields
    drive(6'h3F, 6'h20, 32'h11111111, 32'h22222222, 5'd7, 5'd8, 5'd3, 16'h1234, 26'h0000011, 5'd6);
    step(); expect_all("undef_op", 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);
    // Undefined R-type funct after a valid result
    drive(6'h08, 6'h00, 32'd1, 32'd0, 5'd2, 5'd0, 5'd0, 16'h0001, 26'd0, 5'd0);
    step(); chk("addi_before_undef", result, 32'd2);
    drive(6'h00, 6'h3F, 32'd1, 32'd1, 5'd2, 5'd15, 5'd1, 16'h0, 26'd0, 5'd0);
    step(); expect_all("undef_fn", 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 pc  input  5  word index of the current instruction.
REQ-005 readRs, readRt, readRd  input  32 each  register values selected by the rs, rt and rd fields.
REQ-006 readRdAddress, readRtAddress, shiftNumber  input  5 each  rd field, rt field and shamt field.
REQ-007 I_immediate  input  16, J_immediate  input  26, operand  input  6 (opcode), funct  input  6.
REQ-008 writeBackAddress  output  5  destination register, or jump/branch target.
REQ-009 result  output  32  ALU result.
REQ-010 isZero  output  1  isBranch  output  1  isJAL  output  1.
REQ-011 loadWrite  output  2  10 = lw, 01 = sw, 00 = neither.
REQ-012 loadWriteAddress  output  5  data-memory word address.
REQ-013 inOut  output  2  10 = in, 01 = out, 00 = neither.
REQ-014 inOutAddress  output  5  data-memory word address for in/out.

Function
REQ-015 Decode and compute SHALL be combinational from the inputs; all outputs SHALL be registered; latency is exactly 1 clk.
REQ-016 R-type (operand 0x00) SHALL select on funct, with writeBackAddress = readRdAddress:
- 0x20 add: Rs+Rt
- 0x22 sub: Rs-Rt
- 0x24 and, 0x25 or
- 0x2A slt: signed Rs<Rt gives 1, else 0
- 0x00 sll: Rt<<shamt
- 0x02 srl: logical Rt>>shamt
- 0x03 sra: arithmetic Rt>>>shamt
REQ-017 funct 0x08 (jr) SHALL set isBranch=1, writeBackAddress=readRs[4:0], result=0.
REQ-018 I-type ops SHALL use writeBackAddress = readRtAddress:
- 0x08 addi: Rs+sign-extended imm
- 0x0C andi, 0x0D ori, 0x0E xori: immediate zero-extended
- 0x0F lui: imm<<16
REQ-019 All arithmetic SHALL wrap modulo 2^32; there SHALL be no overflow trap or flag.
REQ-020 beq (0x04) is taken when Rs==Rt; bne (0x05) is taken when Rs!=Rt.
- Taken: isBranch=1, writeBackAddress=(pc+1+imm)[4:0], wrapping mod 32.
- Not taken: isBranch=0, writeBackAddress=0, result=0.
REQ-021 j (0x02) SHALL set isBranch=1, writeBackAddress=J_immediate[4:0], result=0.
REQ-022 jal (0x03) SHALL behave as j, and additionally set isJAL=1 and result=pc+1 (zero-extended, wrapping mod 32).
REQ-023 lw (0x23) SHALL set loadWrite=10, writeBackAddress=readRtAddress, loadWriteAddress=(Rs+sign-extended imm)[4:0], result=0.
REQ-024 sw (0x2B) SHALL use the same address fields as lw, with loadWrite=01.
REQ-025 in (0x20) SHALL set inOut=10 and inOutAddress=I_immediate[4:0].
REQ-026 out (0x21) SHALL set inOut=01 and inOutAddress=I_immediate[4:0].
REQ-027 For lw, sw, in and out, result=0 and isBranch=0.
REQ-028 isZero SHALL be 1 when the next result equals 0.
REQ-029 For beq/bne, isZero SHALL instead be 1 when Rs==Rt.
REQ-030 Unknown operand or funct SHALL act as a nop: all outputs 0 (writeBackAddress=0).
REQ-031 Outputs not named for an instruction SHALL be 0; exactly one of loadWrite, inOut, isBranch is nonzero per instruction, or none.

Reset
REQ-032 When reset=1 at a rising clk edge, all outputs SHALL become 0 on that edge.
REQ-033 Reset SHALL take priority over the decode result on the same edge.
REQ-034 Instruction inputs presented during reset SHALL be discarded.
REQ-035 The first valid output SHALL appear 1 clk after the first edge with reset=0.

Verification
REQ-036 The bench SHALL cover the following directed scenarios:
- addi, operand 0x08, Rs=0, imm=0x0003, rt=16 -> result=3, writeBackAddress=16, isZero=0.
- R-type sra, funct 0x03, Rt=0x80000000, shamt=1, rd=18 -> result=0xC0000000, writeBackAddress=18.
- R-type slt, Rs=0xFFFFFFFF, Rt=1 -> result=1.
- bne, pc=14, Rs=5, Rt=0, imm=1 -> isBranch=1, writeBackAddress=16.
- bne with Rs=Rt -> isBranch=0, writeBackAddress=0, isZero=1.
- jal, pc=23, J_immediate=0x0100018 -> isBranch=1, isJAL=1, writeBackAddress=24, result=24.
- lw, Rs=0, imm=16, rt=0 -> loadWrite=10, loadWriteAddress=16, writeBackAddress=0.
- in, imm=0x001F -> inOut=10, inOutAddress=31.
- Reset asserted mid-stream -> all outputs 0 on that edge.
- Reset asserted mid-stream -> a valid result 1 clk after deassertion.
- Undefined operand 0x3F -> all outputs 0.
